// File: rtl/pwm_phase_monitor_if.sv
// ---------------------------------------------------------------------------
// pwm_phase_monitor_if
// Groups the phase-enable flags and the monitor's status outputs into a
// single bundle.
//   flag_U, flag_V, flag_W : level phase-enable flags (driven by the source)
//   locked                 : start sequence validated
//   err, err_code          : sticky error flag and first error cause
//   angle, sector          : electrical angle 0..359 and angle/60
// Modports:
//   master : the side that drives the flags and observes the status
//   slave  : the monitor, which reads the flags and drives the status
// ---------------------------------------------------------------------------
interface pwm_phase_monitor_if;
    logic       flag_U;
    logic       flag_V;
    logic       flag_W;
    logic       locked;
    logic       err;
    logic [2:0] err_code;
    logic [8:0] angle;
    logic [2:0] sector;

    modport master (
        output flag_U, flag_V, flag_W,
        input  locked, err, err_code, angle, sector
    );

    modport slave (
        input  flag_U, flag_V, flag_W,
        output locked, err, err_code, angle, sector
    );
endinterface

// File: rtl/pwm_phase_monitor.sv
// ---------------------------------------------------------------------------
// pwm_phase_monitor
// Watches the start-up of a three-phase PWM stage. The U, V and W enable
// flags must rise in that order, with V following U by SPACING clocks and
// W following U by 2*SPACING clocks (each within +/-TOL). Once the sequence
// is validated the block reports locked and runs an electrical angle
// counter (0..359) with its 60-degree sector. Any ordering, spacing or
// drop-out problem latches a sticky error with the first cause.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   mon  : pwm_phase_monitor_if.slave (flags in, status out)
// Error codes: 0 none, 1 order, 2 early, 3 late, 4 drop, 5 timeout.
// Optional feature: define PWM_PHASE_MONITOR_TIMEOUT_EN to raise a timeout
// error when the expected V or W rise has not arrived one clock past the
// end of its window. Without it the block waits indefinitely.
// ---------------------------------------------------------------------------
module pwm_phase_monitor #(
    parameter int SPACING = 120,
    parameter int TOL     = 2
) (
    input  logic                clk,
    input  logic                rst,
    pwm_phase_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_V,
        WAIT_W,
        LOCKED,
        ERROR
    } state_t;

    localparam logic [2:0] CODE_ORDER   = 3'd1;
    localparam logic [2:0] CODE_EARLY   = 3'd2;
    localparam logic [2:0] CODE_LATE    = 3'd3;
    localparam logic [2:0] CODE_DROP    = 3'd4;

    localparam logic [8:0] V_LO = 9'(SPACING - TOL);
    localparam logic [8:0] V_HI = 9'(SPACING + TOL);
    localparam logic [8:0] W_LO = 9'(2 * SPACING - TOL);
    localparam logic [8:0] W_HI = 9'(2 * SPACING + TOL);
`ifdef PWM_PHASE_MONITOR_TIMEOUT_EN
    localparam logic [2:0] CODE_TIMEOUT = 3'd5;
    localparam logic [8:0] V_TMO = 9'(SPACING + TOL + 1);
    localparam logic [8:0] W_TMO = 9'(2 * SPACING + TOL + 1);
`endif

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       prevU_q, prevV_q, prevW_q;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic [2:0] errCode_q, errCode_d;
    logic [8:0] angle_q, angle_d;
    logic [2:0] sector;

    logic       riseU, riseV, riseW;
    logic [8:0] cntInc;
    logic       fail;
    logic [2:0] failCode;

    // Next-state logic. The spacing checks look at the count including the
    // current clock (cntInc), so a rise seen N clocks after the U rise is
    // compared against N. Within a state the drop check comes first, so a
    // flag falling in the same cycle as a spacing or order problem is
    // reported as a drop. All failures funnel through one place at the end,
    // and since ERROR never fails again, the first cause is the one kept.
    always_comb begin
        riseU     = mon.flag_U & ~prevU_q;
        riseV     = mon.flag_V & ~prevV_q;
        riseW     = mon.flag_W & ~prevW_q;
        cntInc    = (cnt_q == 9'd511) ? cnt_q : cnt_q + 9'd1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        err_d     = err_q;
        errCode_d = errCode_q;
        angle_d   = angle_q;
        fail      = 1'b0;
        failCode  = 3'd0;

        case (state_q)
            IDLE: begin
                if (riseV || riseW) begin
                    fail     = 1'b1;
                    failCode = CODE_ORDER;
                end else if (riseU) begin
                    cnt_d   = 9'd0;
                    state_d = WAIT_V;
                end
            end

            WAIT_V: begin
                cnt_d = cntInc;
                if (!mon.flag_U) begin
                    fail     = 1'b1;
                    failCode = CODE_DROP;
                end else if (riseW) begin
                    fail     = 1'b1;
                    failCode = CODE_ORDER;
                end else if (riseV) begin
                    if (cntInc < V_LO) begin
                        fail     = 1'b1;
                        failCode = CODE_EARLY;
                    end else if (cntInc > V_HI) begin
                        fail     = 1'b1;
                        failCode = CODE_LATE;
                    end else begin
                        state_d = WAIT_W;
                    end
                end
`ifdef PWM_PHASE_MONITOR_TIMEOUT_EN
                else if (cntInc >= V_TMO) begin
                    fail     = 1'b1;
                    failCode = CODE_TIMEOUT;
                end
`endif
            end

            WAIT_W: begin
                cnt_d = cntInc;
                if (!mon.flag_U || !mon.flag_V) begin
                    fail     = 1'b1;
                    failCode = CODE_DROP;
                end else if (riseW) begin
                    if (cntInc < W_LO) begin
                        fail     = 1'b1;
                        failCode = CODE_EARLY;
                    end else if (cntInc > W_HI) begin
                        fail     = 1'b1;
                        failCode = CODE_LATE;
                    end else begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        angle_d  = 9'd0;
                    end
                end
`ifdef PWM_PHASE_MONITOR_TIMEOUT_EN
                else if (cntInc >= W_TMO) begin
                    fail     = 1'b1;
                    failCode = CODE_TIMEOUT;
                end
`endif
            end

            LOCKED: begin
                if (!mon.flag_U || !mon.flag_V || !mon.flag_W) begin
                    fail     = 1'b1;
                    failCode = CODE_DROP;
                end else begin
                    angle_d = (angle_q == 9'd359) ? 9'd0 : angle_q + 9'd1;
                end
            end

            ERROR: begin
            end

            default: begin
                state_d = ERROR;
            end
        endcase

        if (fail) begin
            state_d   = ERROR;
            err_d     = 1'b1;
            errCode_d = failCode;
            locked_d  = 1'b0;
            angle_d   = 9'd0;
        end
    end

    // State and output registers. Reset clears everything, including the
    // flag history, so flags already high when reset is released are seen
    // as rising on the first clock afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 9'd0;
            prevU_q   <= 1'b0;
            prevV_q   <= 1'b0;
            prevW_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 3'd0;
            angle_q   <= 9'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prevU_q   <= mon.flag_U;
            prevV_q   <= mon.flag_V;
            prevW_q   <= mon.flag_W;
            locked_q  <= locked_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
            angle_q   <= angle_d;
        end
    end

    // Sector follows the registered angle directly, one step per 60 degrees.
    always_comb begin
        if (angle_q < 9'd60)       sector = 3'd0;
        else if (angle_q < 9'd120) sector = 3'd1;
        else if (angle_q < 9'd180) sector = 3'd2;
        else if (angle_q < 9'd240) sector = 3'd3;
        else if (angle_q < 9'd300) sector = 3'd4;
        else                       sector = 3'd5;
    end

    assign mon.locked   = locked_q;
    assign mon.err      = err_q;
    assign mon.err_code = errCode_q;
    assign mon.angle    = angle_q;
    assign mon.sector   = sector;

endmodule
